// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the fetch/decode stage:
//                ALU and compare op encodings, microcode bit positions,
//                RV32I major opcodes and the fetch FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // ALU operation selected by microcode bits [28:25]
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // Branch comparison selected by microcode bits [31:29]
  typedef enum logic [2:0] {
    CMP_NULL = 3'd0,
    CMP_EQ   = 3'd1,
    CMP_NE   = 3'd2,
    CMP_LT   = 3'd3,
    CMP_GE   = 3'd4,
    CMP_LTU  = 3'd5,
    CMP_GEU  = 3'd6,
    CMP_TRUE = 3'd7
  } cmp_ops_e;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // Microcode bit positions
  localparam int unsigned MC_CHK_RS1    = 0;
  localparam int unsigned MC_CHK_RS2    = 1;
  localparam int unsigned MC_REGA_A     = 2;
  localparam int unsigned MC_UP_A       = 3;
  localparam int unsigned MC_JT_A       = 4;
  localparam int unsigned MC_BT_A       = 5;
  localparam int unsigned MC_REGB_B     = 6;
  localparam int unsigned MC_LI_B       = 7;
  localparam int unsigned MC_ST_B       = 8;
  localparam int unsigned MC_PC_B       = 9;
  localparam int unsigned MC_RS2_B      = 10;
  localparam int unsigned MC_MEM_WE     = 11;
  localparam int unsigned MC_ALU_MADDR  = 12;
  localparam int unsigned MC_REGB_MDATA = 13;
  localparam int unsigned MC_JUMP_BR    = 14;
  localparam int unsigned MC_MEM_USE    = 15;
  localparam int unsigned MC_REG_WE     = 16;
  localparam int unsigned MC_UP_RD      = 17;
  localparam int unsigned MC_ALU_RD     = 18;
  localparam int unsigned MC_RET_RD     = 19;
  localparam int unsigned MC_MEM_RD     = 20;
  localparam int unsigned MC_TRUNC_B    = 21;
  localparam int unsigned MC_TRUNC_H    = 22;
  localparam int unsigned MC_SEXT_B     = 23;
  localparam int unsigned MC_SEXT_H     = 24;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // Place the ALU and compare op fields into their microcode positions
  function automatic logic [31:0] pack_ops(input alu_op_e alu, input cmp_ops_e cmp);
    logic [31:0] w;
    w        = '0;
    w[28:25] = alu;
    w[31:29] = cmp;
    return w;
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/microcode_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : microcode_decoder
//  Description : Purely combinational RV32I decoder producing the 32-bit
//                control word, an illegal flag and a no-op flag (FENCE).
//  Revision    : 1.0 - initial release
// ============================================================================
module microcode_decoder
  import cpu_pkg::*;
#(
  parameter bit SUPPRESS_X0_WE = 1'b1
) (
  input  logic [31:0] instr_i,
  output logic [31:0] microcode_o,
  output logic        illegal_o,
  output logic        nop_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rd     = instr_i[11:7];

  // Register/immediate fields are carried to s0 separately; decode ignores them
  logic w_unused_fields;
  assign w_unused_fields = ^instr_i[24:15];

  logic [31:0] mc;
  alu_op_e     alu_op;
  cmp_ops_e    cmp_op;
  logic        illegal;
  logic        nop;

  // Decode the opcode into control bits, ALU op and compare op
  always_comb begin
    mc      = '0;
    alu_op  = ALU_ADD;
    cmp_op  = CMP_NULL;
    illegal = 1'b0;
    nop     = 1'b0;
    case (opcode)
      OPC_LUI: begin
        mc[MC_REG_WE] = 1'b1;
        mc[MC_UP_RD]  = 1'b1;
      end
      OPC_AUIPC: begin
        mc[MC_UP_A]   = 1'b1;
        mc[MC_PC_B]   = 1'b1;
        mc[MC_REG_WE] = 1'b1;
        mc[MC_ALU_RD] = 1'b1;
      end
      OPC_JAL: begin
        mc[MC_JT_A]    = 1'b1;
        mc[MC_PC_B]    = 1'b1;
        mc[MC_JUMP_BR] = 1'b1;
        mc[MC_REG_WE]  = 1'b1;
        mc[MC_RET_RD]  = 1'b1;
        cmp_op         = CMP_TRUE;
      end
      OPC_JALR: begin
        mc[MC_CHK_RS1] = 1'b1;
        mc[MC_REGA_A]  = 1'b1;
        mc[MC_LI_B]    = 1'b1;
        mc[MC_JUMP_BR] = 1'b1;
        mc[MC_REG_WE]  = 1'b1;
        mc[MC_RET_RD]  = 1'b1;
        cmp_op         = CMP_TRUE;
      end
      OPC_BRANCH: begin
        mc[MC_CHK_RS1] = 1'b1;
        mc[MC_CHK_RS2] = 1'b1;
        mc[MC_BT_A]    = 1'b1;
        mc[MC_PC_B]    = 1'b1;
        mc[MC_JUMP_BR] = 1'b1;
        case (funct3)
          3'b000:  cmp_op = CMP_EQ;
          3'b001:  cmp_op = CMP_NE;
          3'b100:  cmp_op = CMP_LT;
          3'b101:  cmp_op = CMP_GE;
          3'b110:  cmp_op = CMP_LTU;
          3'b111:  cmp_op = CMP_GEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        mc[MC_CHK_RS1]   = 1'b1;
        mc[MC_REGA_A]    = 1'b1;
        mc[MC_LI_B]      = 1'b1;
        mc[MC_ALU_MADDR] = 1'b1;
        mc[MC_MEM_USE]   = 1'b1;
        mc[MC_REG_WE]    = 1'b1;
        mc[MC_MEM_RD]    = 1'b1;
        case (funct3)
          3'b000:  mc[MC_SEXT_B]  = 1'b1;
          3'b001:  mc[MC_SEXT_H]  = 1'b1;
          3'b010:  ;
          3'b100:  mc[MC_TRUNC_B] = 1'b1;
          3'b101:  mc[MC_TRUNC_H] = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        mc[MC_CHK_RS1]    = 1'b1;
        mc[MC_CHK_RS2]    = 1'b1;
        mc[MC_REGA_A]     = 1'b1;
        mc[MC_ST_B]       = 1'b1;
        mc[MC_MEM_WE]     = 1'b1;
        mc[MC_ALU_MADDR]  = 1'b1;
        mc[MC_REGB_MDATA] = 1'b1;
        mc[MC_MEM_USE]    = 1'b1;
        case (funct3)
          3'b000:  mc[MC_TRUNC_B] = 1'b1;
          3'b001:  mc[MC_TRUNC_H] = 1'b1;
          3'b010:  ;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        mc[MC_CHK_RS1] = 1'b1;
        mc[MC_REGA_A]  = 1'b1;
        mc[MC_REG_WE]  = 1'b1;
        mc[MC_ALU_RD]  = 1'b1;
        // Shifts take the shamt from the rs2 field; everything else the I-immediate
        case (funct3)
          3'b000: begin mc[MC_LI_B] = 1'b1; alu_op = ALU_ADD;  end
          3'b010: begin mc[MC_LI_B] = 1'b1; alu_op = ALU_SLT;  end
          3'b011: begin mc[MC_LI_B] = 1'b1; alu_op = ALU_SLTU; end
          3'b100: begin mc[MC_LI_B] = 1'b1; alu_op = ALU_XOR;  end
          3'b110: begin mc[MC_LI_B] = 1'b1; alu_op = ALU_OR;   end
          3'b111: begin mc[MC_LI_B] = 1'b1; alu_op = ALU_AND;  end
          3'b001: begin
            mc[MC_RS2_B] = 1'b1;
            alu_op       = ALU_SLL;
            if (funct7 != 7'b0000000) illegal = 1'b1;
          end
          default: begin
            mc[MC_RS2_B] = 1'b1;
            if (funct7 == 7'b0000000)      alu_op  = ALU_SRL;
            else if (funct7 == 7'b0100000) alu_op  = ALU_SRA;
            else                           illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        mc[MC_CHK_RS1] = 1'b1;
        mc[MC_CHK_RS2] = 1'b1;
        mc[MC_REGA_A]  = 1'b1;
        mc[MC_REGB_B]  = 1'b1;
        mc[MC_REG_WE]  = 1'b1;
        mc[MC_ALU_RD]  = 1'b1;
        case (funct3)
          3'b000:  alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      OPC_FENCE: nop = 1'b1;
      default:   illegal = 1'b1;
    endcase

    mc = mc | pack_ops(alu_op, cmp_op);

    // Writes to x0 would only create false hazards in the control unit
    if (SUPPRESS_X0_WE && (rd == 5'd0)) mc[MC_REG_WE] = 1'b0;

    if (illegal || nop) mc = '0;
  end

  assign microcode_o = mc;
  assign illegal_o   = illegal;
  assign nop_o       = nop;

endmodule : microcode_decoder
`default_nettype wire

// File: rtl/instruction_fetch_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_decoder
//  Description : Drives the instruction address from pc, decodes the word
//                returned by the synchronous ROM into the s0 microcode and
//                instruction data, and inserts bubbles after reset, on
//                redirect, on block_inst and (optionally) halts on illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_decoder
  import cpu_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter bit SUPPRESS_X0_WE  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] pc_i,
  input  logic        redirect_i,
  input  logic        block_inst_i,
  output logic [29:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] microcode_s0_o,
  output logic [24:0] instruction_data_s0_o,
  output logic        decode_valid_o,
  output logic        halted_o,
  output logic [29:0] illegal_pc_o
);

  fetch_state_e state_q, state_d;
  logic [29:0]  pc_f1_q;
  logic [31:0]  mc_q, mc_d;
  logic [24:0]  idata_q;
  logic         valid_q, valid_d;
  logic         halted_q, halted_d;
  logic [29:0]  illegal_pc_q, illegal_pc_d;

  logic [31:0]  dec_mc;
  logic         dec_illegal;
  logic         dec_nop;

  // The ROM is addressed straight from pc; its data returns one cycle later
  assign imem_addr_o = pc_i;

  microcode_decoder #(
    .SUPPRESS_X0_WE (SUPPRESS_X0_WE)
  ) u_decoder (
    .instr_i     (imem_rdata_i),
    .microcode_o (dec_mc),
    .illegal_o   (dec_illegal),
    .nop_o       (dec_nop)
  );

  // Next state and s0 contents; priority HALT > redirect > block > illegal > decode
  always_comb begin
    state_d      = state_q;
    mc_d         = '0;
    valid_d      = 1'b0;
    halted_d     = halted_q;
    illegal_pc_d = illegal_pc_q;
    if (state_q == ST_HALT) begin
      state_d = ST_HALT;
    end else if (redirect_i) begin
      // The word arriving now is on the wrong path
      state_d = ST_FLUSH;
    end else if (block_inst_i) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_FILL, ST_FLUSH: state_d = ST_RUN;
        ST_RUN: begin
          if (dec_illegal) begin
            if (HALT_ON_ILLEGAL) begin
              state_d      = ST_HALT;
              halted_d     = 1'b1;
              illegal_pc_d = pc_f1_q;
            end
          end else if (!dec_nop) begin
            mc_d    = dec_mc;
            valid_d = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State, fetch-pc pipeline and s0 output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FILL;
      pc_f1_q      <= '0;
      mc_q         <= '0;
      idata_q      <= '0;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      illegal_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_f1_q      <= pc_i;
      mc_q         <= mc_d;
      idata_q      <= imem_rdata_i[31:7];
      valid_q      <= valid_d;
      halted_q     <= halted_d;
      illegal_pc_q <= illegal_pc_d;
    end
  end

  assign microcode_s0_o        = mc_q;
  assign instruction_data_s0_o = idata_q;
  assign decode_valid_o        = valid_q;
  assign halted_o              = halted_q;
  assign illegal_pc_o          = illegal_pc_q;

endmodule : instruction_fetch_decoder
`default_nettype wire

// File: tb/tb_instruction_fetch_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_decoder
//  Description : Directed self-checking bench with a scoreboard queue; a
//                second instance covers SUPPRESS_X0_WE=0 / HALT_ON_ILLEGAL=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_decoder;

  localparam logic [31:0] I_ADDI1  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_BEQ    = 32'h00208463; // beq  x1,x2,8
  localparam logic [31:0] I_LW     = 32'h0000A183; // lw   x3,0(x1)
  localparam logic [31:0] I_SB     = 32'h00208023; // sb   x2,0(x1)
  localparam logic [31:0] I_LHU    = 32'h0020D203; // lhu  x4,2(x1)
  localparam logic [31:0] I_ADDIX0 = 32'h00108013; // addi x0,x1,1
  localparam logic [31:0] I_BLTU   = 32'h0020E463; // bltu x1,x2,8
  localparam logic [31:0] I_SRAI   = 32'h4030D293; // srai x5,x1,3
  localparam logic [31:0] I_SUB    = 32'h40208333; // sub  x6,x1,x2
  localparam logic [31:0] I_JAL    = 32'h000000EF; // jal  x1,0

  localparam logic [31:0] MC_ADDI    = 32'h00050085;
  localparam logic [31:0] MC_ADDIX0  = 32'h00040085;
  localparam logic [31:0] MC_BEQ     = 32'h20004223;
  localparam logic [31:0] MC_LW      = 32'h00119085;
  localparam logic [31:0] MC_SB      = 32'h0020B907;
  localparam logic [31:0] MC_LHU     = 32'h00519085;
  localparam logic [31:0] MC_BLTU    = 32'hA0004223;
  localparam logic [31:0] MC_SRAI    = 32'h0E050405;
  localparam logic [31:0] MC_SUB     = 32'h02050047;
  localparam logic [31:0] MC_JAL     = 32'hE0094210;

  typedef struct {
    logic        valid;
    logic [31:0] mc;
    logic [24:0] idata;
    logic        halted;
    logic [29:0] ipc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] pc;
  logic        redirect;
  logic        block;
  logic [31:0] rdata = '0;
  logic [31:0] mem [0:31];

  logic [29:0] addr1, addr2, ipc1, ipc2;
  logic [31:0] mc1, mc2;
  logic [24:0] id1, id2;
  logic        v1, v2, h1, h2;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [29:0] last_pc = '0;

  always #5 clk = ~clk;

  // Synchronous instruction ROM
  always @(posedge clk) rdata <= mem[addr1[4:0]];

  instruction_fetch_decoder #(
    .HALT_ON_ILLEGAL (1'b1),
    .SUPPRESS_X0_WE  (1'b1)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .pc_i                  (pc),
    .redirect_i            (redirect),
    .block_inst_i          (block),
    .imem_addr_o           (addr1),
    .imem_rdata_i          (rdata),
    .microcode_s0_o        (mc1),
    .instruction_data_s0_o (id1),
    .decode_valid_o        (v1),
    .halted_o              (h1),
    .illegal_pc_o          (ipc1)
  );

  instruction_fetch_decoder #(
    .HALT_ON_ILLEGAL (1'b0),
    .SUPPRESS_X0_WE  (1'b0)
  ) dut2 (
    .clk                   (clk),
    .rst                   (rst),
    .pc_i                  (pc),
    .redirect_i            (redirect),
    .block_inst_i          (block),
    .imem_addr_o           (addr2),
    .imem_rdata_i          (rdata),
    .microcode_s0_o        (mc2),
    .instruction_data_s0_o (id2),
    .decode_valid_o        (v2),
    .halted_o              (h2),
    .illegal_pc_o          (ipc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  // One clock: queue the expectation, take the edge, compare the s0 outputs
  task automatic tick(input string tag, input logic ev, input logic [31:0] emc,
                      input logic eh, input logic [29:0] eip);
    exp_t e;
    e.valid  = ev;
    e.mc     = emc;
    e.idata  = mem[last_pc[4:0]][31:7];
    e.halted = eh;
    e.ipc    = eip;
    sb.push_back(e);
    chk({tag, ".addr"}, {2'b00, addr1}, {2'b00, pc});
    chk({tag, ".addr2"}, {2'b00, addr2}, {2'b00, pc});
    @(posedge clk);
    last_pc = pc;
    #1;
    e = sb.pop_front();
    chk({tag, ".valid"},  {31'd0, v1}, {31'd0, e.valid});
    chk({tag, ".mc"},     mc1, e.mc);
    chk({tag, ".idata"},  {7'd0, id1}, {7'd0, e.idata});
    chk({tag, ".halted"}, {31'd0, h1}, {31'd0, e.halted});
    chk({tag, ".ipc"},    {2'b00, ipc1}, {2'b00, e.ipc});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = I_ADDI1;
    mem[4]  = I_BEQ;
    mem[8]  = 32'hFFFF_FFFF;
    mem[13] = I_LW;
    mem[14] = I_SB;
    mem[15] = I_LHU;
    mem[16] = I_ADDIX0;
    mem[18] = I_BLTU;
    mem[19] = I_SRAI;
    mem[20] = I_SUB;
    mem[21] = I_JAL;

    rst = 1'b1; pc = '0; redirect = 1'b0; block = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.mc",     mc1, 32'd0);
    chk("rst.valid",  {31'd0, v1}, 32'd0);
    chk("rst.idata",  {7'd0, id1}, 32'd0);
    chk("rst.halted", {31'd0, h1}, 32'd0);
    chk("rst.ipc",    {2'b00, ipc1}, 32'd0);
    chk("rst.valid2", {31'd0, v2}, 32'd0);
    rst = 1'b0;
    last_pc = '0;

    // Fill bubble, then straight-line ADDI stream
    pc = 30'd0; tick("fill",  1'b0, 32'd0,   1'b0, 30'd0);
    pc = 30'd1; tick("addi0", 1'b1, MC_ADDI, 1'b0, 30'd0);
    pc = 30'd2; tick("addi1", 1'b1, MC_ADDI, 1'b0, 30'd0);
    pc = 30'd3; tick("addi2", 1'b1, MC_ADDI, 1'b0, 30'd0);
    pc = 30'd4; tick("addi3", 1'b1, MC_ADDI, 1'b0, 30'd0);
    pc = 30'd5; tick("beq",   1'b1, MC_BEQ,  1'b0, 30'd0);

    // Redirect drops the wrong-path word, FLUSH drops one more
    pc = 30'd12; redirect = 1'b1; tick("redir", 1'b0, 32'd0, 1'b0, 30'd0);
    redirect = 1'b0;
    pc = 30'd13; tick("flush", 1'b0, 32'd0, 1'b0, 30'd0);
    pc = 30'd14; tick("lw",    1'b1, MC_LW, 1'b0, 30'd0);

    // Two blocked cycles, pc replayed by the control unit
    pc = 30'd15; block = 1'b1; tick("blk0", 1'b0, 32'd0, 1'b0, 30'd0);
    pc = 30'd14;               tick("blk1", 1'b0, 32'd0, 1'b0, 30'd0);
    block = 1'b0;
    pc = 30'd15; tick("sb",  1'b1, MC_SB,  1'b0, 30'd0);
    pc = 30'd16; tick("lhu", 1'b1, MC_LHU, 1'b0, 30'd0);

    // Write to x0: suppressed on dut, kept on dut2
    pc = 30'd17; tick("addix0", 1'b1, MC_ADDIX0, 1'b0, 30'd0);
    chk("addix0.mc2",    mc2, MC_ADDI);
    chk("addix0.valid2", {31'd0, v2}, 32'd1);
    pc = 30'd8;  tick("addi17", 1'b1, MC_ADDI, 1'b0, 30'd0);

    // Illegal word at pc 8
    pc = 30'd9;  tick("illegal", 1'b0, 32'd0, 1'b1, 30'd8);
    chk("illegal.valid2",  {31'd0, v2}, 32'd0);
    chk("illegal.halted2", {31'd0, h2}, 32'd0);
    pc = 30'd0;  tick("halt0", 1'b0, 32'd0, 1'b1, 30'd8);
    chk("halt0.mc2",    mc2, MC_ADDI);
    chk("halt0.valid2", {31'd0, v2}, 32'd1);
    pc = 30'd1; redirect = 1'b1; tick("haltredir", 1'b0, 32'd0, 1'b1, 30'd8);
    redirect = 1'b0;
    pc = 30'd2;  tick("halt2", 1'b0, 32'd0, 1'b1, 30'd8);

    // Asynchronous reset out of HALT takes effect before the next edge
    rst = 1'b1; pc = '0;
    #1;
    chk("arst.halted", {31'd0, h1}, 32'd0);
    chk("arst.ipc",    {2'b00, ipc1}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    last_pc = '0;

    pc = 30'd18; tick("fill2", 1'b0, 32'd0,   1'b0, 30'd0);
    pc = 30'd19; tick("bltu",  1'b1, MC_BLTU, 1'b0, 30'd0);
    pc = 30'd20; tick("srai",  1'b1, MC_SRAI, 1'b0, 30'd0);
    pc = 30'd21; tick("sub",   1'b1, MC_SUB,  1'b0, 30'd0);
    pc = 30'd22; tick("jal",   1'b1, MC_JAL,  1'b0, 30'd0);

    // Asynchronous reset mid-stream clears live outputs immediately
    rst = 1'b1; pc = '0;
    #1;
    chk("arst2.valid",  {31'd0, v1}, 32'd0);
    chk("arst2.mc",     mc1, 32'd0);
    chk("arst2.idata",  {7'd0, id1}, 32'd0);
    chk("arst2.valid2", {31'd0, v2}, 32'd0);
    chk("arst2.mc2",    mc2, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_instruction_fetch_decoder
`default_nettype wire
